// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: local RAM, UART TX/RX FIFOs at 0x30000, cycle counter and finish flag; mem_din follows a request by exactly 1 cycle.
// TX writes to a full FIFO are dropped and io_buffer_full warns early; MEM_IO_LOOPBACK_EN feeds popped TX bytes back into the RX FIFO.

module mem_io_fifo #(
  parameter int AW = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !rst_in) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_AW        = 3,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_finish
);
  localparam int DEPTH = 2**FIFO_AW;

  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} src_t;

  logic [7:0]                ram [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]                ram_q;
  logic                      is_io;
  logic [15:0]               io_off;
  logic                      unused_addr_bits;

  logic [31:0] cycle_cnt;
  logic [31:0] snapshot;
  logic [31:0] snap_next;
  logic [7:0]  io_q;
  logic [7:0]  io_next;
  src_t        src;
  logic        finish_set;

  logic              tx_push;
  logic [7:0]        tx_push_data;
  logic              tx_pop;
  logic              tx_empty;
  logic              tx_full_unused;
  logic [FIFO_AW:0]  tx_count;

  logic              rx_push;
  logic [7:0]        rx_push_data;
  logic              rx_pop;
  logic [7:0]        rx_head;
  logic              rx_empty;
  logic              rx_full_unused;
  logic [FIFO_AW:0]  rx_count_unused;

  assign ram_addr         = mem_a[RAM_ADDR_WIDTH-1:0];
  assign is_io            = (mem_a[17:16] == 2'b11);
  assign io_off           = mem_a[15:0];
  assign unused_addr_bits = ^mem_a[31:18];

  always_comb begin
    io_next      = 8'h00;
    snap_next    = snapshot;
    rx_pop       = 1'b0;
    tx_push      = 1'b0;
    tx_push_data = mem_dout;
    finish_set   = 1'b0;
    if (is_io) begin
      if (mem_wr) begin
        case (io_off)
          16'h0000: tx_push = (mem_dout != 8'h00);
          16'h0004: begin
            // The finish marker is a literal zero byte, so it skips the zero filter.
            tx_push      = 1'b1;
            tx_push_data = 8'h00;
            finish_set   = 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (io_off)
          16'h0000: begin
            rx_pop  = 1'b1;
            io_next = rx_empty ? 8'h00 : rx_head;
          end
          16'h0004: begin
            snap_next = cycle_cnt;
            io_next   = cycle_cnt[7:0];
          end
          16'h0005: io_next = snapshot[15:8];
          16'h0006: io_next = snapshot[23:16];
          16'h0007: io_next = snapshot[31:24];
          default:  io_next = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt      <= '0;
      snapshot       <= '0;
      program_finish <= 1'b0;
      io_q           <= 8'h00;
      src            <= SRC_ZERO;
    end else begin
      cycle_cnt      <= cycle_cnt + 32'd1;
      snapshot       <= snap_next;
      program_finish <= program_finish | finish_set;
      io_q           <= io_next;
      src            <= mem_wr ? SRC_ZERO : (is_io ? SRC_IO : SRC_RAM);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && mem_wr && !is_io) ram[ram_addr] <= mem_dout;
    ram_q <= ram[ram_addr];
  end

  always_comb begin
    mem_din = 8'h00;
    case (src)
      SRC_RAM: mem_din = ram_q;
      SRC_IO:  mem_din = io_q;
      default: mem_din = 8'h00;
    endcase
  end

  assign tx_valid       = !tx_empty;
  assign tx_pop         = tx_valid && tx_ready;
  assign io_buffer_full = (DEPTH - int'(tx_count)) <= FULL_MARGIN;

`ifdef MEM_IO_LOOPBACK_EN
  assign rx_push      = tx_pop;
  assign rx_push_data = tx_data;
`else
  assign rx_push      = rx_valid;
  assign rx_push_data = rx_data;
`endif

  mem_io_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push && !rst_in),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full_unused),
    .count     (tx_count)
  );

  mem_io_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_push && !rst_in),
    .push_data (rx_push_data),
    .pop       (rx_pop && !rst_in),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full_unused),
    .count     (rx_count_unused)
  );
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed plan steps plus random traffic against a queue/array reference model.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        program_finish;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_finish (program_finish)
  );

  always #5 clk_in = ~clk_in;

  int total  = 0;
  int passes = 0;

  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  ram_m[int];
  logic [7:0]  tx_log[$];
  int unsigned m_cnt;
  logic [31:0] m_snap;
  logic        m_fin;
  logic [7:0]  exp_din;
  logic        din_known;

  localparam logic [31:0] IDLE = 32'h0003_0008;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input logic [31:0] a, input logic [7:0] d, input logic w,
                       input logic txr, input logic [7:0] rd, input logic rv, input logic rst);
    logic        io;
    logic [15:0] off;
    int          ra;
    logic [7:0]  popped;
    logic [31:0] cnt_now;
    io      = (a[17:16] == 2'b11);
    off     = a[15:0];
    ra      = int'(a % 32'h2_0000);
    popped  = 8'h00;
    cnt_now = m_cnt;
    if (rst) begin
      txq.delete();
      rxq.delete();
      m_fin = 1'b0; m_cnt = 0; m_snap = '0; exp_din = 8'h00; din_known = 1'b1;
      return;
    end
    exp_din   = 8'h00;
    din_known = 1'b1;
    if (txq.size() > 0 && txr) void'(txq.pop_front());
    if (io && !w && off == 16'h0 && rxq.size() > 0) popped = rxq.pop_front();
    if (rv && rxq.size() < 8) rxq.push_back(rd);
    if (w) begin
      if (!io) ram_m[ra] = d;
      else if (off == 16'h0 && d != 8'h00 && txq.size() < 8) txq.push_back(d);
      else if (off == 16'h4) begin
        m_fin = 1'b1;
        if (txq.size() < 8) txq.push_back(8'h00);
      end
    end else if (!io) begin
      din_known = ram_m.exists(ra);
      if (din_known) exp_din = ram_m[ra];
    end else begin
      case (off)
        16'h0: exp_din = popped;
        16'h4: begin m_snap = cnt_now; exp_din = cnt_now[7:0]; end
        16'h5: exp_din = m_snap[15:8];
        16'h6: exp_din = m_snap[23:16];
        16'h7: exp_din = m_snap[31:24];
        default: exp_din = 8'h00;
      endcase
    end
    m_cnt = m_cnt + 1;
  endtask

  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic w,
                      input logic txr, input logic [7:0] rd, input logic rv, input logic rst);
    @(negedge clk_in);
    mem_a = a; mem_dout = d; mem_wr = w; tx_ready = txr;
    rx_data = rd; rx_valid = rv; rst_in = rst;
    if (tx_valid && txr && !rst) tx_log.push_back(tx_data);
    model(a, d, w, txr, rd, rv, rst);
    @(posedge clk_in);
    #1;
    if (din_known) chk("mem_din", 32'(mem_din), 32'(exp_din));
    chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
    chk("io_buffer_full", 32'(io_buffer_full), 32'((8 - txq.size()) <= 2));
    chk("program_finish", 32'(program_finish), 32'(m_fin));
  endtask

  initial begin
    rst_in = 1'b1; mem_a = IDLE; mem_dout = 8'h00; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    step(IDLE, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(IDLE, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_mem_din", 32'(mem_din), 32'h0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_full", 32'(io_buffer_full), 32'h0);
    chk("reset_finish", 32'(program_finish), 32'h0);

    // Counter snapshot five cycles after reset release
    repeat (5) step(IDLE, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("cnt_b0", 32'(mem_din), 32'h05);
    for (int i = 5; i <= 7; i++) begin
      step(32'h30000 + 32'(i), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("cnt_hi", 32'(mem_din), 32'h00);
    end

    // RAM round trip and aliasing
    step(32'h00010, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ram_rt", 32'(mem_din), 32'hA5);
    step(32'h20010, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ram_alias", 32'(mem_din), 32'h3C);

    // TX fill to the warning threshold, zero write ignored, then drain
    repeat (6) step(32'h30000, 8'h48, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("tx6_full", 32'(io_buffer_full), 32'h1);
    chk("tx6_data", 32'(tx_data), 32'h48);
    step(32'h30000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("tx_zero_ign", 32'(dut.tx_count), 32'd6);
    repeat (6) step(IDLE, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("tx_drained", 32'(tx_valid), 32'h0);
    chk("tx_unfull", 32'(io_buffer_full), 32'h0);

    // TX overflow keeps exactly the first eight bytes
    for (int i = 1; i <= 10; i++) step(32'h30000, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tx_log.delete();
    repeat (12) step(IDLE, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("ovf_count", 32'(tx_log.size()), 32'd8);
    for (int i = 0; i < tx_log.size(); i++) chk("ovf_order", 32'(tx_log[i]), 32'(i + 1));

    // RX reads
    step(IDLE, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0);
    step(IDLE, 8'h00, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rx0", 32'(mem_din), 32'h41);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rx1", 32'(mem_din), 32'h42);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rx_empty", 32'(mem_din), 32'h00);

    // A write presented during reset is discarded; RAM survives reset
    step(32'h00020, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h00020, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(32'h00020, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ram_keep", 32'(mem_din), 32'h77);

    // Counter wrap
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cnt = 32'hFFFF_FFFF;
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_pre", 32'(mem_din), 32'hFF);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_post", 32'(mem_din), 32'h00);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      logic        w;
      logic [7:0]  d;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if (sel < 4) begin
        a = (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 1)) << 17);
        w = 1'($urandom_range(0, 1));
      end else begin
        case ($urandom_range(0, 5))
          0: a = 32'h30000;
          1: a = 32'h30004;
          2: a = 32'h30005;
          3: a = 32'h30006;
          4: a = 32'h30007;
          default: a = 32'h30008;
        endcase
        w = (a == 32'h30000) ? 1'($urandom_range(0, 1))
          : (a == 32'h30004) ? ($urandom_range(0, 15) == 0) : 1'b0;
      end
      a = a | (32'($urandom_range(0, 1)) << 24);
      step(a, d, w, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 199) == 0);
    end

    // Finish marker and reset mid-operation
    repeat (10) step(IDLE, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(32'h30004, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("finish_set", 32'(program_finish), 32'h1);
    chk("finish_txv", 32'(tx_valid), 32'h1);
    chk("finish_txd", 32'(tx_data), 32'h00);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_finish", 32'(program_finish), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_din", 32'(mem_din), 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
